frame_write_scheduler: RTL

Sequences the frame buffer's shared write port among its drawing sources. Once per `frame` pulse it grants each enabled source exclusive write access in fixed priority order, index 0 first and index NUM_SOURCES-1 last. It drives the Frame_manager write-source select and releases each grant when the source reports completion. It sits between the frame manager and the draw units (background, starfield, g-sensor calibration), replacing ad-hoc sharing of `write_source_sel`.

---
 rtl/frame_sched_pkg.sv | 21 ++
 rtl/frame_write_scheduler_if.sv | 37 +++
 rtl/frame_sched_watchdog.sv | 32 +++
 rtl/frame_write_scheduler.sv | 130 +++++++++++++
 4 files changed

// File: rtl/frame_sched_pkg.sv
// rtl/frame_sched_pkg.sv - shared state encoding, limits and width helper for the frame write scheduler
// Contents:
//   MAX_SOURCES  largest supported number of write sources
//   state_t      scheduler state encoding (ST_IDLE, ST_SCAN, ST_GRANT)
//   sel_width()  width of write_source_sel, same rule as the frame manager's SOURCE_SEL_ADDRW
package frame_sched_pkg;

    localparam int MAX_SOURCES = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SCAN  = 2'd1;
    localparam state_t ST_GRANT = 2'd2;

    // A single source still needs a 1-bit select.
    function automatic int sel_width(input int num_sources);
        return (num_sources <= 1) ? 1 : $clog2(num_sources);
    endfunction

endpackage

// File: rtl/frame_write_scheduler_if.sv
// rtl/frame_write_scheduler_if.sv - write-port scheduling signals between frame manager, draw units and scheduler
// Signals:
//   frame            new draw pass pulse
//   src_enable       per-source participation mask
//   src_done         per-source completion pulses
//   write_source_sel index of the granted source
//   write_awaited    one-hot grant
//   busy, pass_done, frame_overrun, timeout_flag  pass status
// Modports:
//   master  the scheduler
//   slave   frame manager / draw units
interface frame_write_scheduler_if #(
    parameter int NUM_SOURCES = 3,
    parameter int SEL_W       = frame_sched_pkg::sel_width(NUM_SOURCES)
) ();

    logic                   frame;
    logic [NUM_SOURCES-1:0] src_enable;
    logic [NUM_SOURCES-1:0] src_done;
    logic [SEL_W-1:0]       write_source_sel;
    logic [NUM_SOURCES-1:0] write_awaited;
    logic                   busy;
    logic                   pass_done;
    logic                   frame_overrun;
    logic                   timeout_flag;

    modport master (
        input  frame, src_enable, src_done,
        output write_source_sel, write_awaited, busy, pass_done, frame_overrun, timeout_flag
    );

    modport slave (
        output frame, src_enable, src_done,
        input  write_source_sel, write_awaited, busy, pass_done, frame_overrun, timeout_flag
    );

endinterface

// File: rtl/frame_sched_watchdog.sv
// rtl/frame_sched_watchdog.sv - per-grant cycle counter that flags a source holding the write port too long
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     restart the count (grant entry)
//   run       count this cycle (grant held)
//   expired   high in the cycle the count reaches TIMEOUT_CYCLES-1 while running
module frame_sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [31:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 32'd1;
        end
    end

    // The first grant cycle sees count 0, so expiry lands on the TIMEOUT_CYCLES-th grant cycle.
    assign expired = run && (count == 32'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/frame_write_scheduler.sv
// rtl/frame_write_scheduler.sv - per-frame fixed-priority sequencing of the frame buffer's shared write port
// Optional feature: FRAME_SCHED_TIMEOUT_EN builds the per-grant watchdog and the sticky timeout_flag.
// Ports:
//   clk  clock (clk_25 domain)
//   rst  asynchronous active-high reset
//   bus  frame_write_scheduler_if.master: frame/src_enable/src_done in,
//        write_source_sel/write_awaited/busy/pass_done/frame_overrun/timeout_flag out
module frame_write_scheduler import frame_sched_pkg::*; #(
    parameter int NUM_SOURCES    = 3,
    parameter int SEL_W          = sel_width(NUM_SOURCES),
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic                     clk,
    input logic                     rst,
    frame_write_scheduler_if.master bus
);

    localparam int               IDX_W    = SEL_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SOURCES);

    if (NUM_SOURCES < 1 || NUM_SOURCES > MAX_SOURCES) begin : g_bad_cfg
        $error("frame_write_scheduler: NUM_SOURCES out of range");
    end

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [NUM_SOURCES-1:0] mask;
    logic [NUM_SOURCES-1:0] grant_q;
    logic [SEL_W-1:0]       sel_q;

    logic [NUM_SOURCES-1:0] idx_onehot;
    logic                   idx_enabled;
    logic                   idx_done;
    logic                   in_grant;
    logic                   scan_end;
    logic                   grant_entry;
    logic                   timed_out;
    logic                   release_grant;

    // Shift rather than bit-select so idx == NUM_SOURCES simply yields an empty one-hot.
    assign idx_onehot  = NUM_SOURCES'(1) << idx;
    assign idx_enabled = |(mask & idx_onehot);
    assign idx_done    = |(bus.src_done & idx_onehot);
    assign in_grant    = (state == ST_GRANT);
    assign scan_end    = (state == ST_SCAN) && (idx == LAST_IDX);
    assign grant_entry = (state == ST_SCAN) && !scan_end && idx_enabled;

`ifdef FRAME_SCHED_TIMEOUT_EN
    logic wd_expired;
    logic timeout_q;

    frame_sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant_entry),
        .run     (in_grant),
        .expired (wd_expired)
    );

    // A done arriving together with expiry is an ordinary completion.
    assign timed_out = in_grant && !idx_done && wd_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (timed_out) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.timeout_flag = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timed_out        = 1'b0;
    assign bus.timeout_flag = 1'b0;
`endif

    assign release_grant = in_grant && (idx_done || timed_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            mask    <= '0;
            grant_q <= '0;
            sel_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.frame) begin
                        mask  <= bus.src_enable;
                        idx   <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_end) begin
                        sel_q <= '0;
                        state <= ST_IDLE;
                    end else if (idx_enabled) begin
                        grant_q <= idx_onehot;
                        sel_q   <= idx[SEL_W-1:0];
                        state   <= ST_GRANT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_GRANT: begin
                    // Returning through SCAN guarantees a dead cycle between grants.
                    if (release_grant) begin
                        grant_q <= '0;
                        idx     <= idx + IDX_W'(1);
                        state   <= ST_SCAN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.write_awaited    = grant_q;
    assign bus.write_source_sel = sel_q;
    assign bus.busy             = (state != ST_IDLE);
    assign bus.pass_done        = scan_end;
    assign bus.frame_overrun    = bus.frame && (state != ST_IDLE);

endmodule
